md_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the five-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds the result internally for a fixed latency. Commits the result to HI/LO and raises the stall request that freezes F/D while a HI/LO consumer waits. The HI/LO outputs feed the E-stage MFHI/MFLO mux and the HI/LO fields of the M and W pipeline registers.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_if.sv | 28 ++
 rtl/md_calc.sv | 49 ++++
 rtl/md_ctrl.sv | 84 ++++++++
 tb/tb_md_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding, default latencies and a small op-class helper.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// E-stage <-> multiply/divide unit signal bundle.
//
// Handshake: start is a single-cycle request qualified by op and killed by
// cancel in the same cycle. It is only honoured while busy is low; the
// hazard unit never issues while busy is high, so there is no ready signal.
// HI/LO always show the architectural (committed) values.
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, cancel, A, B, md_use_D,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, op, cancel, A, B, md_use_D,
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the four
// arithmetic ops, including the divide-by-zero and signed-overflow cases.
module md_calc import md_pkg::*; (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] sdiv_b;
    logic [31:0] udiv_b;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    always_comb begin
        smul   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul   = {32'd0, a} * {32'd0, b};
        abs_a  = a[31] ? (~a + 32'd1) : a;
        abs_b  = b[31] ? (~b + 32'd1) : b;
        // Keep a zero divisor away from the dividers; the result is overridden below.
        sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        udiv_b = (b == 32'd0) ? 32'd1 : b;
        sq_mag = abs_a / sdiv_b;
        sr_mag = abs_a % sdiv_b;
        sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
        sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;
        uq     = a / udiv_b;
        ur     = a % udiv_b;
        result = 64'd0;
        case (op)
            MD_MULT:  result = smul;
            MD_MULTU: result = umul;
            MD_DIV:   result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {sr, sq};
            MD_DIVU:  result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {ur, uq};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer owning HI/LO. The result is computed at issue,
// held in pend_hi/pend_lo for a fixed latency, then committed.
module md_ctrl import md_pkg::*; #(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus,
    output logic state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [63:0]      calc_result;
    logic             accept;
    logic             launch;

    md_calc u_calc (
        .op     (bus.op),
        .a      (bus.A),
        .b      (bus.B),
        .result (calc_result)
    );

    // Request qualification: a cancelled start is dropped outright.
    always_comb begin
        accept = bus.start & ~bus.cancel;
        launch = accept & is_muldiv(bus.op);
    end

    // FSM, latency counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        pend_hi <= calc_result[63:32];
                        pend_lo <= calc_result[31:0];
                        cnt     <= ((bus.op == MD_MULT) || (bus.op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                        state   <= ST_BUSY;
                    end else if (accept && (bus.op == MD_MTHI)) begin
                        hi_q <= bus.A;
                    end else if (accept && (bus.op == MD_MTLO)) begin
                        lo_q <= bus.A;
                    end
                end
                default: begin
                    // Cancel and start are ignored here: the in-flight op belongs to an older instruction.
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        hi_q  <= pend_hi;
                        lo_q  <= pend_lo;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (state == ST_BUSY);
    assign bus.md_stall = bus.md_use_D & (bus.busy | launch);
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed cases with literal expectations followed by
// randomized ops, all compared each cycle against a timestamp-based model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    logic state_dbg;
    md_if bus ();

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int ia;
        int ib;
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        int q;
        int r;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = a;
        ub = b;
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model state: committed HI/LO, pending results, and the edge index at
    // which the current op commits (busy while that edge is still ahead).
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int edge_n      = 0;
    int m_commit_at = 0;

    function automatic logic model_busy();
        return m_commit_at > edge_n;
    endfunction

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (reset) begin
            m_hi        <= 32'd0;
            m_lo        <= 32'd0;
            m_commit_at <= 0;
            exp_q.delete();
        end else if (m_commit_at == edge_n + 1 && exp_q.size() > 0) begin
            {m_hi, m_lo} <= exp_q.pop_front();
        end else if (m_commit_at <= edge_n && bus.start && !bus.cancel) begin
            if (bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
                exp_q.push_back(ref_md(bus.op, bus.A, bus.B));
                m_commit_at <= edge_n + 1 + ((bus.op inside {MD_MULT, MD_MULTU}) ? MC : DC);
            end else if (bus.op == MD_MTHI) begin
                m_hi <= bus.A;
            end else if (bus.op == MD_MTLO) begin
                m_lo <= bus.A;
            end
        end
    end

    always @(posedge clk) begin
        assert (reset || !(bus.start && bus.busy))
        else begin
            n_err++;
            $display("FAIL start_while_busy @%0t: start issued while busy", $time);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(model_busy()));
            chk("md_stall", 64'(bus.md_stall),
                64'(bus.md_use_D & (model_busy() |
                    (bus.start & !bus.cancel & (bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})))));
            chk("HI", 64'(bus.HI), 64'(m_hi));
            chk("LO", 64'(bus.LO), 64'(m_lo));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic cxl, output logic stall_t);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        bus.md_use_D = use_d;
        bus.cancel   = cxl;
        @(negedge clk);
        stall_t = bus.md_stall;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = MD_NONE;
    endtask

    // Counts busy (and stalled) cycles; returns at the negedge of the first idle cycle.
    task automatic wait_done(output int nb, output int ns);
        nb = 0;
        ns = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            nb++;
            if (bus.md_stall === 1'b1) ns++;
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    // ---------------- stimulus ----------------
    logic       st;
    int         nb;
    int         ns;
    int         gap;
    int         guard;
    logic [2:0] r_op;

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = MD_NONE;
        bus.cancel   = 1'b0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.md_use_D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Model pins.
        chk("ref_mult_m1_m1", ref_md(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h1);
        chk("ref_div_m7_2", ref_md(MD_DIV, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Reset state.
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        next_drive();

        // MULT -1 * 2.
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, st);
        wait_done(nb, ns);
        chk("mult_busy_cycles", 64'(nb), 64'd5);
        chk("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.LO), 64'hFFFF_FFFE);
        next_drive();

        // MULTU 0xFFFFFFFF * 2 back-to-back.
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, st);
        wait_done(nb, ns);
        chk("multu_busy_cycles", 64'(nb), 64'd5);
        chk("multu_hi", 64'(bus.HI), 64'h1);
        chk("multu_lo", 64'(bus.LO), 64'hFFFF_FFFE);
        next_drive();

        // DIV -7 / 2 with a HI/LO user in D: stall T .. T+10.
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, st);
        chk("div_stall_at_issue", 64'(st), 64'd1);
        wait_done(nb, ns);
        chk("div_busy_cycles", 64'(nb), 64'd10);
        chk("div_stall_cycles", 64'(ns), 64'd10);
        chk("div_stall_released", 64'(bus.md_stall), 64'd0);
        chk("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        chk("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);
        next_drive();
        bus.md_use_D = 1'b0;

        // DIVU by zero.
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, st);
        wait_done(nb, ns);
        chk("divu0_hi", 64'(bus.HI), 64'd7);
        chk("divu0_lo", 64'(bus.LO), 64'hFFFF_FFFF);
        next_drive();

        // Signed overflow.
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, st);
        wait_done(nb, ns);
        chk("divovf_hi", 64'(bus.HI), 64'd0);
        chk("divovf_lo", 64'(bus.LO), 64'h8000_0000);
        next_drive();

        // MTHI / MTLO: one-cycle update, never busy or stalling.
        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0, st);
        chk("mthi_stall_at_issue", 64'(st), 64'd0);
        @(negedge clk);
        chk("mthi_hi", 64'(bus.HI), 64'h1234_5678);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_stall", 64'(bus.md_stall), 64'd0);
        next_drive();
        issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, st);
        @(negedge clk);
        chk("mtlo_lo", 64'(bus.LO), 64'hCAFE_F00D);
        next_drive();

        // Cancelled MULT is discarded.
        issue(MD_MULT, 32'd3, 32'd3, 1'b1, 1'b1, st);
        chk("cancel_stall", 64'(st), 64'd0);
        @(negedge clk);
        chk("cancel_busy", 64'(bus.busy), 64'd0);
        chk("cancel_hi", 64'(bus.HI), 64'h1234_5678);
        chk("cancel_lo", 64'(bus.LO), 64'hCAFE_F00D);
        next_drive();
        bus.md_use_D = 1'b0;

        // Cancel pulsed mid-DIV does not stop it.
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0, st);
        repeat (3) next_drive();
        bus.cancel = 1'b1;
        next_drive();
        bus.cancel = 1'b0;
        wait_done(nb, ns);
        chk("cxl_mid_remaining_busy", 64'(nb), 64'd6);
        chk("cxl_mid_hi", 64'(bus.HI), 64'd2);
        chk("cxl_mid_lo", 64'(bus.LO), 64'd14);
        next_drive();

        // Reset in the middle of a DIV.
        issue(MD_DIV, 32'd50, 32'd3, 1'b0, 1'b0, st);
        repeat (2) next_drive();
        reset = 1'b1;
        next_drive();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hi", 64'(bus.HI), 64'd0);
        chk("rst_mid_lo", 64'(bus.LO), 64'd0);
        next_drive();
        issue(MD_MULT, 32'd3, 32'd4, 1'b0, 1'b0, st);
        wait_done(nb, ns);
        chk("post_rst_busy_cycles", 64'(nb), 64'd5);
        chk("post_rst_hi", 64'(bus.HI), 64'd0);
        chk("post_rst_lo", 64'(bus.LO), 64'd12);
        next_drive();

        // Reset beats a simultaneous start.
        issue(MD_MTHI, 32'h55, 32'd0, 1'b0, 1'b0, st);
        reset = 1'b1;
        issue(MD_MTHI, 32'hAA, 32'd0, 1'b0, 1'b0, st);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wins_hi", 64'(bus.HI), 64'd0);
        chk("rst_wins_lo", 64'(bus.LO), 64'd0);
        next_drive();

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                bus.md_use_D = 1'($urandom_range(0, 1));
                next_drive();
            end
            r_op = 3'($urandom_range(0, 7));
            issue(r_op, pick_val(), pick_val(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), st);
            guard = 0;
            while (model_busy() && guard < 64) begin
                bus.md_use_D = 1'($urandom_range(0, 1));
                bus.cancel   = 1'($urandom_range(0, 5) == 0);
                next_drive();
                bus.cancel = 1'b0;
                guard++;
            end
            if (guard >= 64) chk("rand_idle_timeout", 64'd1, 64'd0);
        end

        repeat (3) next_drive();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
